nn_infer_sched: RTL and testbench

Inference scheduler between the frame-capture buffer and the zyNet core. On a start pulse it fetches NUM_PIXELS pixels from the capture buffer by address and streams them into zyNet's AXI-Stream input with full ready/valid backpressure. It then waits for zyNet's `intr`, performs one AXI-Lite read of the result register, and presents the class with a one-cycle valid strobe.

---
 rtl/nn_infer_sched.sv | 171 +++++++++++++++++
 tb/tb_nn_infer_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_infer_sched.sv
// nn_infer_sched: pixel fetch/stream into zyNet, intr wait, AXI-Lite result read.
// Optional intr watchdog: define NN_SCHED_TIMEOUT_EN.
module nn_infer_sched #(
  parameter int          DATA_WIDTH     = 8,
  parameter int          NUM_PIXELS     = 784,
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [31:0] RESULT_ADDR    = 32'h8,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  output logic [DATA_WIDTH-1:0] axis_in_data,
  output logic                  axis_in_data_valid,
  input  logic                  axis_in_data_ready,
  input  logic                  intr,
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [7:0]            result,
  output logic                  result_valid,
  output logic                  error
);

  localparam int CW = $clog2(NUM_PIXELS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_WAIT, S_AR, S_R, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         iss_q;
  logic [CW-1:0]         sent_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_post;
  logic                  rd_vld_q;
  logic                  start_ok;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  last_pop;
  logic                  tmo;

  assign start_ok = (state_q == S_IDLE) && start;
  assign pop      = (cnt_q != 2'd0) && axis_in_data_ready;
  assign push     = rd_vld_q;
  assign last_pop = pop && (sent_q == CW'(NUM_PIXELS - 1));
  assign cnt_post = cnt_q - {1'b0, pop};

  // Credit counts the slot freed by this cycle's pop so one pixel/cycle holds.
  assign issue = (state_q == S_STREAM)
              && (iss_q < CW'(NUM_PIXELS))
              && ((cnt_post + {1'b0, rd_vld_q}) < 2'd2);

  assign buf_rd_en          = issue;
  assign axis_in_data       = fifo_q[rd_ptr_q];
  assign axis_in_data_valid = (cnt_q != 2'd0);
  assign m_axi_araddr       = RESULT_ADDR;

`ifdef NN_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wd_q <= '0;
    end else if (state_q != S_WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign tmo = (wd_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (last_pop) state_d = S_WAIT;
      S_WAIT: begin
        if (intr) state_d = S_AR;
        else if (tmo) state_d = S_ERR;
      end
      S_AR:     if (m_axi_arready) state_d = S_R;
      S_R: begin
        if (m_axi_rvalid) begin
          state_d = (m_axi_rresp == 2'b00) ? S_DONE : S_ERR;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= S_IDLE;
      iss_q         <= '0;
      sent_q        <= '0;
      buf_rd_addr   <= '0;
      rd_vld_q      <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      busy          <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      result_valid  <= 1'b0;
      result        <= '0;
      error         <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= issue;

      if (start_ok) iss_q <= '0;
      else if (issue) iss_q <= iss_q + 1'b1;

      if (start_ok) sent_q <= '0;
      else if (pop) sent_q <= sent_q + 1'b1;

      // Address parks on the last pixel instead of running past it.
      if (start_ok) begin
        buf_rd_addr <= '0;
      end else if (issue && (iss_q != CW'(NUM_PIXELS - 1))) begin
        buf_rd_addr <= buf_rd_addr + 1'b1;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= buf_rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};

      busy          <= (state_d != S_IDLE);
      m_axi_arvalid <= (state_d == S_AR);
      m_axi_rready  <= (state_d == S_R);
      result_valid  <= (state_d == S_DONE);

      if ((state_q == S_R) && m_axi_rvalid && (m_axi_rresp == 2'b00)) begin
        result <= m_axi_rdata[7:0];
      end

      if (start_ok) error <= 1'b0;
      else if (state_d == S_ERR) error <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{m_axi_rdata[31:8], (TIMEOUT_CYCLES != 0)};

endmodule

// File: tb/tb_nn_infer_sched.sv
// tb_nn_infer_sched: randomized bench for nn_infer_sched.
// Scoreboard: buffer holds addr^salt, stream must replay it in order.
module tb_nn_infer_sched;

  localparam int          NUM = 784;
  localparam logic [31:0] RA  = 32'h8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        buf_rd_en;
  logic [9:0]  buf_rd_addr;
  logic [7:0]  buf_rd_data;
  logic [7:0]  axis_in_data;
  logic        axis_in_data_valid;
  logic        axis_in_data_ready;
  logic        intr;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [7:0]  result;
  logic        result_valid;
  logic        error;

  nn_infer_sched #(
    .DATA_WIDTH(8),
    .NUM_PIXELS(NUM),
    .ADDR_WIDTH(10),
    .RESULT_ADDR(RA),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .start(start),
    .busy(busy),
    .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .axis_in_data(axis_in_data),
    .axis_in_data_valid(axis_in_data_valid),
    .axis_in_data_ready(axis_in_data_ready),
    .intr(intr),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .result(result),
    .result_valid(result_valid),
    .error(error)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_iss = 0, n_xfer = 0, n_rv = 0, n_ar = 0;
  int seq_mis = 0, addr_mis = 0, addr_over = 0;
  int first_cyc = 0, last_cyc = 0;
  int xbase = 0, ibase = 0, rvbase = 0, arbase = 0;
  int smbase = 0, ambase = 0;
  int s_cyc = 0;
  int rmode = 0;
  logic [7:0] salt = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input int i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ salt;
  endfunction

  always @(posedge clk) begin
    if (buf_rd_en) buf_rd_data <= buf_rd_addr[7:0] ^ salt;
  end

  always @(posedge clk) begin
    if (m_axi_arvalid && m_axi_arready) n_ar <= n_ar + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (buf_rd_addr > 10'(NUM - 1)) addr_over <= addr_over + 1;
      if (buf_rd_en) begin
        if (int'(buf_rd_addr) != n_iss - ibase) addr_mis <= addr_mis + 1;
        n_iss <= n_iss + 1;
      end
      if (axis_in_data_valid && axis_in_data_ready) begin
        if (axis_in_data !== pix(n_xfer - xbase)) seq_mis <= seq_mis + 1;
        if (n_xfer == xbase) first_cyc <= cyc;
        last_cyc <= cyc;
        n_xfer   <= n_xfer + 1;
      end
      if (result_valid) n_rv <= n_rv + 1;
    end
  end

  initial begin
    int stall;
    stall = 0;
    axis_in_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) begin
        axis_in_data_ready = 1'b1;
      end else if (stall > 0) begin
        axis_in_data_ready = 1'b0;
        stall--;
      end else if ($urandom_range(0, 49) == 0) begin
        axis_in_data_ready = 1'b0;
        stall = 19;
      end else begin
        axis_in_data_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    xbase  = n_xfer;
    ibase  = n_iss;
    rvbase = n_rv;
    arbase = n_ar;
    smbase = seq_mis;
    ambase = addr_mis;
    start  = 1'b1;
    s_cyc  = cyc;
    tick();
    start = 1'b0;
    chk("busy_n1", busy, 1);
    chk("rden_n1", buf_rd_en, 1);
    chk("addr_n1", buf_rd_addr, 0);
    chk("err_clr", error, 0);
  endtask

  task automatic wait_xfers(input int n, input int lim);
    int k;
    k = 0;
    while ((n_xfer - xbase) < n && k < lim) begin
      tick();
      k++;
    end
    chk("xfer_wait", (n_xfer - xbase) >= n, 1);
  endtask

  task automatic stream_checks();
    chk("n_xfer", n_xfer - xbase, NUM);
    chk("n_issue", n_iss - ibase, NUM);
    chk("seq", seq_mis - smbase, 0);
    chk("addr_seq", addr_mis - ambase, 0);
    chk("addr_max", addr_over, 0);
  endtask

  task automatic serve_read(input int ard, input int rdly,
                            input logic [31:0] data, input logic [1:0] resp);
    int k;
    int stab;
    k = 0;
    stab = 0;
    while (!m_axi_arvalid && k < 100) begin
      tick();
      k++;
    end
    chk("arv_seen", m_axi_arvalid, 1);
    chk("araddr", m_axi_araddr, RA);
    chk("rready_ar", m_axi_rready, 0);
    repeat (ard) begin
      tick();
      if (!m_axi_arvalid || m_axi_araddr != RA) stab++;
    end
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    chk("ar_drop", m_axi_arvalid, 0);
    repeat (rdly) begin
      if (!m_axi_rready) stab++;
      tick();
    end
    chk("rready_r", m_axi_rready, 1);
    m_axi_rdata  = data;
    m_axi_rresp  = resp;
    m_axi_rvalid = 1'b1;
    tick();
    m_axi_rvalid = 1'b0;
    chk("axi_stable", stab, 0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n         = 1'b0;
    start         = 1'b0;
    intr          = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    m_axi_rvalid  = 1'b0;
    repeat (3) tick();

    chk("rst_busy", busy, 0);
    chk("rst_rden", buf_rd_en, 0);
    chk("rst_addr", buf_rd_addr, 0);
    chk("rst_valid", axis_in_data_valid, 0);
    chk("rst_data", axis_in_data, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, RA);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // full-rate run, buffer holds addr[7:0]
    salt  = 8'h00;
    rmode = 0;
    do_start();
    wait_xfers(NUM, 5000);
    chk("first_valid", first_cyc - s_cyc, 3);
    chk("last_xfer", last_cyc - s_cyc, NUM + 2);
    stream_checks();
    repeat (10) tick();
    chk("no_early_ar", m_axi_arvalid, 0);
    chk("busy_wait", busy, 1);
    intr = 1'b1;
    tick();
    chk("ar_lat", m_axi_arvalid, 1);
    serve_read(0, 0, 32'h0000_0003, 2'b00);
    chk("rv_a", result_valid, 1);
    chk("result_a", result, 8'h03);
    intr = 1'b0;
    tick();
    chk("rv_pulse_a", result_valid, 0);
    chk("idle_a", busy, 0);
    chk("n_rv_a", n_rv - rvbase, 1);
    chk("n_ar_a", n_ar - arbase, 1);

    // random backpressure with stalls, slow AXI, error response
    salt  = 8'($urandom);
    rmode = 1;
    do_start();
    wait_xfers(NUM, 20000);
    rmode = 0;
    stream_checks();
    intr = 1'b1;
    serve_read(5, 7, $urandom, 2'b10);
    intr = 1'b0;
    chk("err_b", error, 1);
    chk("rv_b", result_valid, 0);
    tick();
    chk("idle_b", busy, 0);
    repeat (5) tick();
    chk("err_sticky", error, 1);
    chk("result_hold", result, 8'h03);
    chk("n_rv_b", n_rv - rvbase, 0);
    chk("n_ar_b", n_ar - arbase, 1);

    // start mid-stream and early intr are both ignored
    salt = 8'($urandom);
    do_start();
    intr = 1'b1;
    wait_xfers(300, 2000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_xfers(NUM, 5000);
    stream_checks();
    d = $urandom;
    serve_read(0, 0, d, 2'b00);
    chk("rv_c", result_valid, 1);
    chk("result_c", result, d[7:0]);
    intr = 1'b0;
    repeat (5) tick();
    chk("n_xfer_c", n_xfer - xbase, NUM);
    chk("n_ar_c", n_ar - arbase, 1);
    chk("n_rv_c", n_rv - rvbase, 1);

    // reset at pixel 400, then a clean restart
    salt = 8'($urandom);
    do_start();
    wait_xfers(400, 2000);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", axis_in_data_valid, 0);
    chk("mrst_rden", buf_rd_en, 0);
    chk("mrst_result", result, 0);
    tick();
    rst_n = 1'b1;
    tick();
    salt = 8'($urandom);
    do_start();
    wait_xfers(NUM, 5000);
    chk("first_valid_d", first_cyc - s_cyc, 3);
    stream_checks();
    intr = 1'b1;
    d = $urandom;
    serve_read(1, 2, d, 2'b00);
    chk("rv_d", result_valid, 1);
    chk("result_d", result, d[7:0]);
    intr = 1'b0;
    tick();
    chk("n_rv_d", n_rv - rvbase, 1);

`ifdef NN_SCHED_TIMEOUT_EN
    // intr never comes: watchdog drives ERR
    salt = 8'($urandom);
    do_start();
    wait_xfers(NUM, 5000);
    begin
      int k;
      k = 0;
      while (cyc < last_cyc + 100 && k < 500) begin
        tick();
        k++;
      end
    end
    chk("tmo_pre_err", error, 0);
    chk("tmo_pre_busy", busy, 1);
    tick();
    chk("tmo_err", error, 1);
    tick();
    chk("tmo_idle", busy, 0);
    chk("tmo_err_hold", error, 1);
    chk("tmo_no_rv", n_rv - rvbase, 0);
    chk("tmo_no_ar", n_ar - arbase, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
